// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the two-port ROM read arbiter.
// Optional starvation guard is enabled by defining ROM_ARB_STARVE_GUARD_EN.
package rom_arb_pkg;

    localparam int unsigned ROM_WIDTH        = 32;
    localparam int unsigned ROM_DEPTH        = 2048;
    localparam int unsigned ROM_STARVE_LIMIT = 4;
    localparam int unsigned STARVE_W         = $clog2(ROM_STARVE_LIMIT + 1);

    typedef enum logic {
        PORT_IF,
        PORT_LD
    } port_e;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [ROM_WIDTH-1:0] data;
    } resp_t;

endpackage

// File: rtl/rom_arb_slot.sv
// Per-port registered response slot: eligibility, capture on grant, release on drain.
module rom_arb_slot
    import rom_arb_pkg::*;
#(
    parameter int unsigned WIDTH = ROM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             resp_ready,
    input  logic             grant,
    input  logic             load_err,
    input  logic [WIDTH-1:0] load_data,
    output logic             eligible,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_data
);

    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A slot that drains this cycle can accept the next request on the same edge.
    assign eligible = req_valid & (~valid_q | resp_ready);

    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        if (grant) begin
            valid_d = 1'b1;
            err_d   = load_err;
            data_d  = load_err ? '0 : load_data;
        end else if (valid_q && resp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign resp_data  = data_q;

endmodule

// File: rtl/rom_arbiter.sv
// Shares the asynchronous ROM read port between instruction fetch and load units.
// Define ROM_ARB_STARVE_GUARD_EN to let fetch win once after STARVE_LIMIT lost cycles.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned WIDTH        = ROM_WIDTH,
    parameter int unsigned DEPTH        = ROM_DEPTH,
    parameter int unsigned STARVE_LIMIT = ROM_STARVE_LIMIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_req_valid,
    input  logic [WIDTH-1:0] if_req_addr,
    output logic             if_req_ready,
    output logic             if_resp_valid,
    output logic [WIDTH-1:0] if_resp_data,
    output logic             if_resp_err,
    input  logic             if_resp_ready,
    input  logic             ld_req_valid,
    input  logic [WIDTH-1:0] ld_req_addr,
    output logic             ld_req_ready,
    output logic             ld_resp_valid,
    output logic [WIDTH-1:0] ld_resp_data,
    output logic             ld_resp_err,
    input  logic             ld_resp_ready,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata
);

    localparam logic [WIDTH-3:0] DEPTH_WORDS = (WIDTH-2)'(DEPTH);

    logic  if_elig, ld_elig;
    logic  grant_if, grant_ld;
    logic  force_if;
    logic  if_err, ld_err;
    port_e sel;

    assign if_err = (if_req_addr[1:0] != 2'b00) || (if_req_addr[WIDTH-1:2] >= DEPTH_WORDS);
    assign ld_err = (ld_req_addr[1:0] != 2'b00) || (ld_req_addr[WIDTH-1:2] >= DEPTH_WORDS);

    // No grants while reset is held, so req_ready reads 0 even though it is combinational.
    always_comb begin
        grant_if    = ~reset & if_elig & (~ld_elig | force_if);
        grant_ld    = ~reset & ld_elig & ~grant_if;
        sel         = grant_ld ? PORT_LD : PORT_IF;
        rom_address = (sel == PORT_LD) ? ld_req_addr : if_req_addr;
    end

    assign if_req_ready = grant_if;
    assign ld_req_ready = grant_ld;

`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign force_if = (starve_q == LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (grant_if || !if_elig) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0 && (STARVE_LIMIT != 0);
`endif

    rom_arb_slot #(.WIDTH(WIDTH)) u_if_slot (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (if_req_valid),
        .resp_ready (if_resp_ready),
        .grant      (grant_if),
        .load_err   (if_err),
        .load_data  (rom_rdata),
        .eligible   (if_elig),
        .resp_valid (if_resp_valid),
        .resp_err   (if_resp_err),
        .resp_data  (if_resp_data)
    );

    rom_arb_slot #(.WIDTH(WIDTH)) u_ld_slot (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (ld_req_valid),
        .resp_ready (ld_resp_ready),
        .grant      (grant_ld),
        .load_err   (ld_err),
        .load_data  (rom_rdata),
        .eligible   (ld_elig),
        .resp_valid (ld_resp_valid),
        .resp_err   (ld_resp_err),
        .resp_data  (ld_resp_data)
    );

endmodule
